tx_scrambler: RTL and testbench

//  Data scrambler stage directly downstream of the TX MCU bit-stream source.
//  - Scrambles the DATA-field serial bit stream with the 802.11a polynomial
//    S(x) = x^7 + x^4 + 1.
//  - Passes SIGNAL-field bits through unscrambled.
//  - Forwards the rate tag on a registered valid/ready output to the convolutional encoder.
//  - Takes its seed from the MCU scram_seed/scram_load pair.

---
 rtl/tx_scrambler.sv | 112 +++++++++++
 tb/tb_tx_scrambler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_scrambler.sv
// Scrambles DATA-field bits with S(x) = x^7 + x^4 + 1; SIGNAL-field bits bypass. Optional tail zeroing under SCRAM_TAIL_ZERO_EN.
// Latency: 1 cycle through a single output register, full throughput.
// Backpressure: input stalls while the output is held or while a seed load is in progress.
module tx_scrambler #(
    parameter logic [6:0] DEF_SEED = 7'b1111111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scram_din,
    input  logic        scram_din_vld,
    input  logic        scram_din_sig_flag,
    input  logic [3:0]  scram_din_rate_con,
    output logic        scram_din_rdy,
    input  logic [6:0]  scram_seed,
    input  logic        scram_load,
    input  logic [11:0] scram_din_length,
    output logic        scram_dout,
    output logic        scram_dout_vld,
    output logic        scram_dout_sig_flag,
    output logic [3:0]  scram_dout_rate_con,
    input  logic        scram_dout_rdy
);

    logic [6:0]  lfsr_q, lfsr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        dout_q, dout_d;
    logic        vld_q, vld_d;
    logic        sig_q, sig_d;
    logic [3:0]  rate_q, rate_d;
    logic        xfer, data_xfer, fb, scr_bit, tail_zero;

    assign scram_din_rdy = (~vld_q | scram_dout_rdy) & ~scram_load;
    assign xfer          = scram_din_vld & scram_din_rdy;
    assign data_xfer     = xfer & ~scram_din_sig_flag;
    assign fb            = lfsr_q[6] ^ lfsr_q[3];

`ifdef SCRAM_TAIL_ZERO_EN
    logic [11:0] len_q;
    logic [15:0] tail_lo, tail_hi;

    // Tail follows 16 SERVICE bits plus the PSDU; 16 bits is enough for LEN=4095.
    assign tail_lo   = 16'd16 + {1'b0, len_q, 3'b000};
    assign tail_hi   = tail_lo + 16'd5;
    assign tail_zero = (cnt_q >= tail_lo) && (cnt_q <= tail_hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
        end else if (scram_load) begin
            len_q <= scram_din_length;
        end
    end
`else
    logic unused_len;
    assign unused_len = ^scram_din_length;
    assign tail_zero  = 1'b0;
`endif

    assign scr_bit = scram_din_sig_flag ? scram_din
                                        : ((scram_din ^ fb) & ~tail_zero);

    always_comb begin
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        vld_d  = vld_q;
        sig_d  = sig_q;
        rate_d = rate_q;

        // Load blocks the input side, so it can never collide with a data advance.
        if (scram_load) begin
            lfsr_d = scram_seed;
            cnt_d  = '0;
        end else if (data_xfer) begin
            lfsr_d = {lfsr_q[5:0], fb};
            cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end

        if (xfer) begin
            dout_d = scr_bit;
            vld_d  = 1'b1;
            sig_d  = scram_din_sig_flag;
            rate_d = scram_din_rate_con;
        end else if (scram_dout_rdy) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= DEF_SEED;
            cnt_q  <= '0;
            dout_q <= 1'b0;
            vld_q  <= 1'b0;
            sig_q  <= 1'b0;
            rate_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            sig_q  <= sig_d;
            rate_q <= rate_d;
        end
    end

    assign scram_dout          = dout_q;
    assign scram_dout_vld      = vld_q;
    assign scram_dout_sig_flag = sig_q;
    assign scram_dout_rate_con = rate_q;

endmodule

// File: tb/tb_tx_scrambler.sv
// Directed bench for tx_scrambler: hand-computed sequences plus a small queue model for the stall test.
module tb_tx_scrambler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scram_din;
    logic        scram_din_vld;
    logic        scram_din_sig_flag;
    logic [3:0]  scram_din_rate_con;
    logic        scram_din_rdy;
    logic [6:0]  scram_seed;
    logic        scram_load;
    logic [11:0] scram_din_length;
    logic        scram_dout;
    logic        scram_dout_vld;
    logic        scram_dout_sig_flag;
    logic [3:0]  scram_dout_rate_con;
    logic        scram_dout_rdy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tx_scrambler dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .scram_din           (scram_din),
        .scram_din_vld       (scram_din_vld),
        .scram_din_sig_flag  (scram_din_sig_flag),
        .scram_din_rate_con  (scram_din_rate_con),
        .scram_din_rdy       (scram_din_rdy),
        .scram_seed          (scram_seed),
        .scram_load          (scram_load),
        .scram_din_length    (scram_din_length),
        .scram_dout          (scram_dout),
        .scram_dout_vld      (scram_dout_vld),
        .scram_dout_sig_flag (scram_dout_sig_flag),
        .scram_dout_rate_con (scram_dout_rate_con),
        .scram_dout_rdy      (scram_dout_rdy)
    );

    task automatic chkb(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic lfb(input logic [6:0] s);
        return s[6] ^ s[3];
    endfunction

    function automatic logic [6:0] lstep(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[3]};
    endfunction

    initial begin
        logic [15:0] exp1;
        logic [4:0]  exp2;
        logic [4:0]  exp4;
        logic [19:0] pat;
        logic [6:0]  ms;
        logic        q[$];
        int          k;
        logic        e;

        exp1 = 16'b0000_1110_1111_0010;
        exp2 = 5'b00001;
        exp4 = 5'b11110;
        pat  = 20'hB3C5A;

        rst_n              = 1'b0;
        scram_din          = 1'b0;
        scram_din_vld      = 1'b0;
        scram_din_sig_flag = 1'b0;
        scram_din_rate_con = 4'h0;
        scram_seed         = 7'h00;
        scram_load         = 1'b0;
        scram_din_length   = 12'd0;
        scram_dout_rdy     = 1'b1;

        #12;
        chkb("rst_vld",    scram_dout_vld, 1'b0);
        chkb("rst_dout",   scram_dout, 1'b0);
        chkb("rst_sig",    scram_dout_sig_flag, 1'b0);
        chkw("rst_rate",   16'(scram_dout_rate_con), 16'h0);
        chkb("rst_din_rdy", scram_din_rdy, 1'b1);
        #10 rst_n = 1'b1;
        tick();

        // 1: seed 7F, 16 zero data bits
        scram_seed = 7'h7F;
        scram_load = 1'b1;
        #1 chkb("t1_load_rdy", scram_din_rdy, 1'b0);
        tick();
        scram_load         = 1'b0;
        scram_din_vld      = 1'b1;
        scram_din          = 1'b0;
        scram_din_rate_con = 4'hB;
        for (int i = 0; i < 16; i++) begin
            tick();
            chkb($sformatf("t1_bit%0d", i), scram_dout, exp1[15-i]);
        end
        chkb("t1_vld", scram_dout_vld, 1'b1);
        chkw("t1_rate", 16'(scram_dout_rate_con), 16'hB);
        scram_din_vld = 1'b0;
        tick();
        chkb("t1_vld_clear", scram_dout_vld, 1'b0);

        // 2: 24 SIGNAL bits bypass, then data resumes with an unadvanced LFSR
        scram_load = 1'b1;
        tick();
        scram_load         = 1'b0;
        scram_din_vld      = 1'b1;
        scram_din_sig_flag = 1'b1;
        scram_din_rate_con = 4'hD;
        for (int i = 0; i < 24; i++) begin
            scram_din = (i % 2 == 0);
            tick();
            chkb($sformatf("t2_sig%0d", i), scram_dout, (i % 2 == 0));
        end
        chkb("t2_sig_flag", scram_dout_sig_flag, 1'b1);
        chkw("t2_rate", 16'(scram_dout_rate_con), 16'hD);
        scram_din_sig_flag = 1'b0;
        scram_din          = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chkb($sformatf("t2_data%0d", i), scram_dout, exp2[4-i]);
        end
        chkb("t2_sig_flag_clr", scram_dout_sig_flag, 1'b0);
        scram_din_vld = 1'b0;
        tick();

        // 3: downstream stall of 5 cycles in a data stream
        scram_load = 1'b1;
        tick();
        scram_load = 1'b0;
        ms = 7'h7F;
        k  = 0;
        for (int cyc = 0; cyc < 200 && (k < 20 || q.size() > 0); cyc++) begin
            scram_din_vld  = (k < 20);
            scram_din      = (k < 20) ? pat[k] : 1'b0;
            scram_dout_rdy = !(cyc >= 4 && cyc < 9);
            #1;
            if (scram_dout_vld) begin
                if (q.size() == 0) begin
                    chkw("t3_extra_bit", 16'(q.size()), 16'd1);
                end else begin
                    chkb($sformatf("t3_out_c%0d", cyc), scram_dout, q[0]);
                    if (scram_dout_rdy) void'(q.pop_front());
                end
                if (!scram_dout_rdy) chkb($sformatf("t3_stall_rdy_c%0d", cyc), scram_din_rdy, 1'b0);
            end
            if (scram_din_vld && scram_din_rdy) begin
                q.push_back(scram_din ^ lfb(ms));
                ms = lstep(ms);
                k++;
            end
            tick();
        end
        scram_din_vld  = 1'b0;
        scram_dout_rdy = 1'b1;
        chkw("t3_all_sent", 16'(k), 16'd20);
        chkw("t3_drained", 16'(q.size()), 16'd0);
        tick();

        // 4: load coincident with a valid input bit
        scram_seed = 7'h7F;
        scram_load = 1'b1;
        tick();
        scram_load    = 1'b0;
        scram_din_vld = 1'b1;
        scram_din     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chkb($sformatf("t4_pre%0d", i), scram_dout, exp1[15-i]);
        end
        scram_din  = 1'b1;
        scram_seed = 7'h55;
        scram_load = 1'b1;
        #1 chkb("t4_load_rdy", scram_din_rdy, 1'b0);
        tick();
        chkb("t4_not_accepted", scram_dout_vld, 1'b0);
        scram_load = 1'b0;
        scram_din  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chkb($sformatf("t4_seed55_%0d", i), scram_dout, exp4[4-i]);
        end
        scram_din_vld = 1'b0;
        tick();

`ifdef SCRAM_TAIL_ZERO_EN
        // 5: LEN=2, all-ones data, tail bits 32..37 forced to zero
        scram_seed       = 7'h7F;
        scram_din_length = 12'd2;
        scram_load       = 1'b1;
        tick();
        scram_load    = 1'b0;
        scram_din_vld = 1'b1;
        scram_din     = 1'b1;
        ms = 7'h7F;
        for (int i = 0; i < 40; i++) begin
            e  = (i >= 32 && i <= 37) ? 1'b0 : ~lfb(ms);
            ms = lstep(ms);
            tick();
            chkb($sformatf("t5_bit%0d", i), scram_dout, e);
        end
        scram_din_vld = 1'b0;
        tick();
`endif

        // 6: reset mid-stream restarts from the default seed
        scram_seed = 7'h55;
        scram_load = 1'b1;
        tick();
        scram_load    = 1'b0;
        scram_din_vld = 1'b1;
        scram_din     = 1'b0;
        tick();
        tick();
        chkb("t6_pre_vld", scram_dout_vld, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chkb("t6_rst_vld", scram_dout_vld, 1'b0);
        chkb("t6_rst_dout", scram_dout, 1'b0);
        chkw("t6_rst_rate", 16'(scram_dout_rate_con), 16'h0);
        scram_din_vld = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        chkb("t6_post_rdy", scram_din_rdy, 1'b1);
        scram_din_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chkb($sformatf("t6_def%0d", i), scram_dout, exp2[4-i]);
        end
        scram_din_vld = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
